// File: rtl/vcap_pkg.sv
// Shared types and constants for the video capture line writer.
package vcap_pkg;

    localparam int unsigned VCAP_FIFO_DEPTH = 512;
    localparam int unsigned VCAP_PXL_W      = 12;
    localparam int unsigned VCAP_LINE_W     = 9;
    localparam int unsigned VCAP_CNT_W      = $clog2(VCAP_FIFO_DEPTH) + 1;
    localparam int unsigned VCAP_LEN_W      = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_REQ,
        S_XFER,
        S_DONE,
        S_GUARD
    } vcap_state_t;

endpackage

// File: rtl/vcap_burst_split.sv
// Splits one line into bursts of at most BURST_LEN beats: tracks words left,
// word offset, beats left in the current burst, and the registered len/last.
module vcap_burst_split
    import vcap_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VCAP_CNT_W-1:0] words,
    input  logic                  start,
    input  logic                  beat,
    output logic [VCAP_LEN_W-1:0] len,
    output logic                  last,
    output logic [VCAP_CNT_W-1:0] offset,
    output logic                  done
);

    logic [VCAP_CNT_W-1:0] rem;
    logic [VCAP_CNT_W-1:0] rem_n;
    logic [VCAP_CNT_W-1:0] off_n;
    logic [VCAP_LEN_W-1:0] brem;
    logic [VCAP_LEN_W-1:0] brem_n;
    logic [VCAP_LEN_W-1:0] len_n;

    function automatic logic [VCAP_LEN_W-1:0] clip_len(input logic [VCAP_CNT_W-1:0] n);
        return (n >= VCAP_CNT_W'(BURST_LEN)) ? VCAP_LEN_W'(BURST_LEN) : VCAP_LEN_W'(n);
    endfunction

    // Next counter values: load a new line, arm a burst, or consume a beat.
    always_comb begin
        rem_n  = rem;
        off_n  = offset;
        brem_n = brem;
        len_n  = len;
        if (load) begin
            rem_n  = words;
            off_n  = '0;
            brem_n = '0;
            len_n  = clip_len(words);
        end else if (start) begin
            brem_n = len;
        end else if (beat) begin
            rem_n  = rem - VCAP_CNT_W'(1);
            off_n  = offset + VCAP_CNT_W'(1);
            brem_n = brem - VCAP_LEN_W'(1);
            if (brem == VCAP_LEN_W'(1)) begin
                len_n = clip_len(rem_n);
            end
        end
    end

    // Line is finished once the beat being accepted leaves nothing behind.
    assign done = (rem_n == '0);

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            offset <= '0;
            brem   <= '0;
            len    <= '0;
            last   <= 1'b0;
        end else begin
            rem    <= rem_n;
            offset <= off_n;
            brem   <= brem_n;
            len    <= len_n;
            last   <= (brem_n == VCAP_LEN_W'(1));
        end
    end

endmodule

// File: rtl/vcap_line_writer.sv
// Drains one captured line from the line FIFO into frame memory as bursts.
// Optional feature macro: VCAP_DBUF_EN (double-buffered frames).
module vcap_line_writer
    import vcap_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned STRIDE_LOG2 = 9
) (
    input  logic                   i_ram_clk,
    input  logic                   i_reset_n,
    input  logic                   i_fifo_active,
    input  logic [VCAP_LINE_W-1:0] i_fifo_line,
    input  logic [VCAP_PXL_W-1:0]  i_fifo_data,
    input  logic [11:0]            i_x_size,
    input  logic [ADDR_W-1:0]      i_frame_base,
    output logic                   o_fifo_next,
    output logic                   o_fifo_reset,
    output logic                   o_wr_req,
    input  logic                   i_wr_gnt,
    output logic [ADDR_W-1:0]      o_wr_addr,
    output logic [6:0]             o_wr_len,
    output logic                   o_wr_valid,
    input  logic                   i_wr_ready,
    output logic [15:0]            o_wr_data,
    output logic                   o_wr_last,
    output logic                   o_busy,
    output logic                   o_frame_buf,
    output logic [7:0]             o_ovf_cnt
);

    vcap_state_t            state;
    logic [VCAP_LINE_W-1:0] line_q;
    logic [ADDR_W-1:0]      base_q;
    logic [ADDR_W-1:0]      line_base_c;
    logic [VCAP_CNT_W-1:0]  words_c;
    logic [VCAP_CNT_W-1:0]  split_off;
    logic                   split_done;
    logic                   beat;
    logic                   buf_n;

    assign beat        = o_wr_valid & i_wr_ready;
    assign o_fifo_next = beat;
    assign o_wr_data   = o_wr_valid ? {4'b0, i_fifo_data} : 16'h0000;
    assign words_c     = (i_x_size >= 12'(VCAP_FIFO_DEPTH - 1)) ? VCAP_CNT_W'(VCAP_FIFO_DEPTH)
                                                                 : VCAP_CNT_W'(i_x_size + 12'd1);
    assign line_base_c = i_frame_base
                       + (ADDR_W'(buf_n) << (STRIDE_LOG2 + 9))
                       + (ADDR_W'(i_fifo_line) << STRIDE_LOG2);

`ifdef VCAP_DBUF_EN
    logic buf_q;

    assign buf_n       = buf_q ^ (i_fifo_line == '0);
    assign o_frame_buf = buf_q;

    // Flip frame buffer whenever a new frame (line 0) starts.
    always_ff @(posedge i_ram_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            buf_q <= 1'b0;
        end else if (state == S_LATCH) begin
            buf_q <= buf_n;
        end
    end
`else
    assign buf_n       = 1'b0;
    assign o_frame_buf = 1'b0;
`endif

    vcap_burst_split #(
        .BURST_LEN(BURST_LEN)
    ) u_split (
        .clk   (i_ram_clk),
        .rst_n (i_reset_n),
        .load  (state == S_LATCH),
        .words (words_c),
        .start ((state == S_REQ) && i_wr_gnt),
        .beat  (beat),
        .len   (o_wr_len),
        .last  (o_wr_last),
        .offset(split_off),
        .done  (split_done)
    );

    // Line sequencer with registered handshake outputs.
    always_ff @(posedge i_ram_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            line_q       <= '0;
            base_q       <= '0;
            o_wr_addr    <= '0;
            o_wr_req     <= 1'b0;
            o_wr_valid   <= 1'b0;
            o_fifo_reset <= 1'b0;
            o_busy       <= 1'b0;
            o_ovf_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_fifo_active) begin
                        state  <= S_LATCH;
                        o_busy <= 1'b1;
                    end
                end
                S_LATCH: begin
                    line_q    <= i_fifo_line;
                    base_q    <= line_base_c;
                    o_wr_addr <= line_base_c;
                    o_wr_req  <= 1'b1;
                    state     <= S_REQ;
                end
                S_REQ: begin
                    if (i_wr_gnt) begin
                        o_wr_req   <= 1'b0;
                        o_wr_valid <= 1'b1;
                        state      <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (beat) begin
                        o_wr_addr <= base_q + ADDR_W'(split_off) + ADDR_W'(1);
                        if (o_wr_last) begin
                            o_wr_valid <= 1'b0;
                            if (split_done) begin
                                o_fifo_reset <= 1'b1;
                                state        <= S_DONE;
                            end else begin
                                o_wr_req <= 1'b1;
                                state    <= S_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    o_fifo_reset <= 1'b0;
                    if ((i_fifo_line != line_q) && (o_ovf_cnt != 8'hFF)) begin
                        o_ovf_cnt <= o_ovf_cnt + 8'd1;
                    end
                    state <= S_GUARD;
                end
                S_GUARD: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vcap_line_writer.sv
// Randomised bench for vcap_line_writer with a queue-based line/burst model.
module tb_vcap_line_writer;
    import vcap_pkg::*;

    localparam int unsigned BL = 8;
    localparam int unsigned AW = 22;
    localparam int unsigned SL = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_fifo_active;
    logic [8:0]    i_fifo_line;
    logic [11:0]   i_fifo_data;
    logic [11:0]   i_x_size;
    logic [AW-1:0] i_frame_base;
    logic          o_fifo_next;
    logic          o_fifo_reset;
    logic          o_wr_req;
    logic          i_wr_gnt;
    logic [AW-1:0] o_wr_addr;
    logic [6:0]    o_wr_len;
    logic          o_wr_valid;
    logic          i_wr_ready;
    logic [15:0]   o_wr_data;
    logic          o_wr_last;
    logic          o_busy;
    logic          o_frame_buf;
    logic [7:0]    o_ovf_cnt;

    always #5 clk = ~clk;

    vcap_line_writer #(.BURST_LEN(BL), .ADDR_W(AW), .STRIDE_LOG2(SL)) dut (
        .i_ram_clk(clk), .i_reset_n(rst_n), .i_fifo_active(i_fifo_active),
        .i_fifo_line(i_fifo_line), .i_fifo_data(i_fifo_data), .i_x_size(i_x_size),
        .i_frame_base(i_frame_base), .o_fifo_next(o_fifo_next), .o_fifo_reset(o_fifo_reset),
        .o_wr_req(o_wr_req), .i_wr_gnt(i_wr_gnt), .o_wr_addr(o_wr_addr), .o_wr_len(o_wr_len),
        .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_data(o_wr_data),
        .o_wr_last(o_wr_last), .o_busy(o_busy), .o_frame_buf(o_frame_buf), .o_ovf_cnt(o_ovf_cnt)
    );

    typedef struct packed { logic [AW-1:0] addr; logic [6:0] len; } burst_t;
    typedef struct packed { logic [AW-1:0] addr; logic [11:0] data; logic last; } beat_t;

    int     total = 0;
    int     bad = 0;
    logic [11:0] fifo_q[$];
    burst_t exp_bursts[$];
    burst_t seen_bursts[$];
    beat_t  exp_beats[$];
    int     last_idx[$];
    int     ovf_exp = 0;
    logic   buf_exp = 1'b0;
    int     mode = 0;
    logic   tog = 1'b1;
    logic   prev_reqgnt = 1'b0;
    int     pops, resets, beats_acc, cyc, first_req;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic set_head();
        i_fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 12'h000;
    endtask

    task automatic drive_hs();
        case (mode)
            0: begin i_wr_gnt = 1'b1; i_wr_ready = 1'b1; end
            1: begin i_wr_gnt = 1'b1; i_wr_ready = tog; tog = ~tog; end
            default: begin
                i_wr_gnt   = 1'($urandom_range(0, 1));
                i_wr_ready = ($urandom_range(0, 9) < 6);
            end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   64'(o_wr_req), 64'(0));
        chk({tag, "_valid"}, 64'(o_wr_valid), 64'(0));
        chk({tag, "_addr"},  64'(o_wr_addr), 64'(0));
        chk({tag, "_len"},   64'(o_wr_len), 64'(0));
        chk({tag, "_last"},  64'(o_wr_last), 64'(0));
        chk({tag, "_data"},  64'(o_wr_data), 64'(0));
        chk({tag, "_pop"},   64'(o_fifo_next), 64'(0));
        chk({tag, "_frst"},  64'(o_fifo_reset), 64'(0));
        chk({tag, "_busy"},  64'(o_busy), 64'(0));
        chk({tag, "_fbuf"},  64'(o_frame_buf), 64'(0));
        chk({tag, "_ovf"},   64'(o_ovf_cnt), 64'(0));
    endtask

    // One clock: drive handshakes, check outputs mid-cycle, then update the model.
    task automatic step();
        logic accept, reqgnt, rst_seen;
        @(negedge clk);
        drive_hs();
        #1;
        if (prev_reqgnt) begin
            chk("valid_after_gnt", 64'(o_wr_valid), 64'(1));
            chk("req_drop_after_gnt", 64'(o_wr_req), 64'(0));
        end
        if (o_wr_req) begin
            if (exp_bursts.size() == 0) fail_now("unexpected_req");
            else begin
                chk("burst_addr", 64'(o_wr_addr), 64'(exp_bursts[0].addr));
                chk("burst_len", 64'(o_wr_len), 64'(exp_bursts[0].len));
                chk("valid_in_req", 64'(o_wr_valid), 64'(0));
            end
        end
        if (o_wr_valid) begin
            if (exp_beats.size() == 0) fail_now("extra_beat");
            else begin
                chk("beat_addr", 64'(o_wr_addr), 64'(exp_beats[0].addr));
                chk("beat_data", 64'(o_wr_data), 64'({4'b0, exp_beats[0].data}));
                chk("beat_last", 64'(o_wr_last), 64'(exp_beats[0].last));
            end
            chk("pop_strobe", 64'(o_fifo_next), 64'(i_wr_ready));
        end else begin
            chk("no_pop", 64'(o_fifo_next), 64'(0));
        end
        if (o_wr_req && first_req < 0) first_req = cyc;
        accept   = o_wr_valid & i_wr_ready;
        reqgnt   = o_wr_req & i_wr_gnt;
        rst_seen = o_fifo_reset;
        if (reqgnt && exp_bursts.size() > 0) begin
            seen_bursts.push_back({o_wr_addr, o_wr_len});
            void'(exp_bursts.pop_front());
        end
        if (accept) begin
            beats_acc++;
            if (o_wr_last) last_idx.push_back(beats_acc);
            if (exp_beats.size() > 0) void'(exp_beats.pop_front());
        end
        prev_reqgnt = reqgnt;
        @(posedge clk);
        #1;
        if (accept) begin
            pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            set_head();
        end
        if (rst_seen) begin
            resets++;
            i_fifo_active = 1'b0;
        end
        cyc++;
    endtask

    // Build the expected bursts/beats of a line from its index and length, then raise the flag.
    task automatic prep_line(input int ln, input int xs, output int words);
        longint b;
        logic [11:0] d;
        beat_t bt;
        burst_t bu;
        words = (xs >= 511) ? 512 : xs + 1;
`ifdef VCAP_DBUF_EN
        if (ln == 0) buf_exp = ~buf_exp;
`endif
        b = longint'(i_frame_base) + longint'(buf_exp) * (longint'(1) << (SL + 9))
          + longint'(ln) * (longint'(1) << SL);
        fifo_q.delete(); exp_beats.delete(); exp_bursts.delete();
        seen_bursts.delete(); last_idx.delete();
        for (int i = 0; i < words; i++) begin
            d = 12'($urandom);
            fifo_q.push_back(d);
            bt.addr = AW'(b + longint'(i));
            bt.data = d;
            bt.last = ((i % BL) == BL - 1) || (i == words - 1);
            exp_beats.push_back(bt);
        end
        for (int o = 0; o < words; o += BL) begin
            bu.addr = AW'(b + longint'(o));
            bu.len  = 7'(((words - o) < BL) ? (words - o) : BL);
            exp_bursts.push_back(bu);
        end
        pops = 0; resets = 0; beats_acc = 0; cyc = 0; first_req = -1;
        i_fifo_line   = 9'(ln);
        i_x_size      = 12'(xs);
        i_fifo_active = 1'b1;
        set_head();
    endtask

    task automatic run_line(input int ln, input int xs, input int end_ln);
        int words;
        logic [AW-1:0] save_base;
        bit pert;
        save_base = i_frame_base;
        prep_line(ln, xs, words);
        pert = 1'b0;
        while (!(resets > 0 && !o_busy) && cyc < 6000) begin
            step();
            if (!pert && first_req >= 0) begin
                pert         = 1'b1;
                i_x_size     = 12'($urandom);
                i_frame_base = AW'($urandom);
                i_fifo_line  = 9'(end_ln);
            end
        end
        if (cyc >= 6000) fail_now("line_timeout");
        chk("req_latency", 64'(first_req), 64'(2));
        chk("pops", 64'(pops), 64'(words));
        chk("fifo_reset_pulses", 64'(resets), 64'(1));
        chk("beats_left", 64'(exp_beats.size()), 64'(0));
        chk("bursts_left", 64'(exp_bursts.size()), 64'(0));
        if ((end_ln % 512) != ln && ovf_exp < 255) ovf_exp++;
        chk("ovf_cnt", 64'(o_ovf_cnt), 64'(ovf_exp));
        chk("frame_buf", 64'(o_frame_buf), 64'(buf_exp));
        chk("busy_end", 64'(o_busy), 64'(0));
        i_frame_base = save_base;
    endtask

    task automatic abort_line(input int ln, input int xs);
        int words;
        prep_line(ln, xs, words);
        while (beats_acc < 5 && cyc < 2000) step();
        if (cyc >= 2000) fail_now("abort_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        fifo_q.delete(); exp_beats.delete(); exp_bursts.delete();
        i_fifo_active = 1'b0;
        set_head();
        ovf_exp = 0; buf_exp = 1'b0; prev_reqgnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_busy", 64'(o_busy), 64'(0));
        chk("post_abort_req", 64'(o_wr_req), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ln, xs, sel;
        rst_n = 1'b0; i_fifo_active = 1'b0; i_fifo_line = '0; i_fifo_data = '0;
        i_x_size = '0; i_frame_base = 22'h001000; i_wr_gnt = 1'b0; i_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        mode = 0;
        run_line(3, 15, 3);
        chk("t1_nbursts", 64'(seen_bursts.size()), 64'(2));
        chk("t1_addr0", 64'(seen_bursts[0].addr), 64'(22'h001600));
        chk("t1_len0", 64'(seen_bursts[0].len), 64'(8));
        chk("t1_addr1", 64'(seen_bursts[1].addr), 64'(22'h001608));
        chk("t1_len1", 64'(seen_bursts[1].len), 64'(8));
        chk("t1_pops", 64'(pops), 64'(16));

        run_line(4, 9, 4);
        chk("t2_len0", 64'(seen_bursts[0].len), 64'(8));
        chk("t2_len1", 64'(seen_bursts[1].len), 64'(2));
        chk("t2_nlast", 64'(last_idx.size()), 64'(2));
        chk("t2_last0", 64'(last_idx[0]), 64'(8));
        chk("t2_last1", 64'(last_idx[1]), 64'(10));
        chk("t2_pops", 64'(pops), 64'(10));

        mode = 1; tog = 1'b1;
        run_line(7, 20, 7);

        mode = 0;
        run_line(5, 9, 6);
        chk("t4_ovf_one", 64'(o_ovf_cnt), 64'(1));

        mode = 2;
        for (int i = 0; i < 12; i++) begin
            ln  = int'($urandom_range(1, 511));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: xs = 0;
                1: xs = 511;
                2: xs = 4095;
                3: xs = int'($urandom_range(0, 40));
                4: xs = int'($urandom_range(100, 300));
                default: xs = 510;
            endcase
            run_line(ln, xs, ($urandom_range(0, 3) == 0) ? (ln ^ 1) : ln);
        end

        i_frame_base = 22'h3FFE00;
        run_line(511, 63, 511);
        chk("wrap_addr0", 64'(seen_bursts[0].addr), 64'(22'h03FC00));
        i_frame_base = 22'h001000;

        mode = 0;
        abort_line(9, 40);
        mode = 2;
        run_line(10, 30, 10);

        mode = 0;
        run_line(0, 3, 0);
`ifdef VCAP_DBUF_EN
        chk("dbuf_l0_buf", 64'(o_frame_buf), 64'(1));
        chk("dbuf_l0_addr", 64'(seen_bursts[0].addr), 64'(22'h041000));
`else
        chk("dbuf_l0_buf", 64'(o_frame_buf), 64'(0));
        chk("dbuf_l0_addr", 64'(seen_bursts[0].addr), 64'(22'h001000));
`endif
        run_line(1, 3, 1);
        run_line(2, 3, 2);
        run_line(0, 3, 0);
        chk("dbuf_l0b_buf", 64'(o_frame_buf), 64'(0));
        chk("dbuf_l0b_addr", 64'(seen_bursts[0].addr), 64'(22'h001000));

        for (int i = 0; i < 300; i++) begin
            ln = int'($urandom_range(0, 510));
            run_line(ln, 0, ln + 1);
        end
        chk("ovf_saturated", 64'(o_ovf_cnt), 64'(255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vcap_line_writer.md
# vcap_line_writer

Ram-clock-side sequencer that drains one captured video line from the capture block's line FIFO into frame memory. When the capture block flags a complete line, it computes the line's base address and splits the line into fixed-length write bursts toward the memory controller. It pops one FIFO word per accepted beat, then releases the capture block's line flag. It sits between the capture block's FIFO outputs and a memory-controller write port.

## Interface
- `BURST_LEN`, default 8: maximum beats per burst; power of two, 2..64.
- `ADDR_W`, default 22: word-address width.
- `STRIDE_LOG2`, default 9: log2 of words per frame-memory line.
- `i_ram_clk` in, 1: sole clock.
- `i_reset_n` in, 1: asynchronous, active-low reset.
- `i_fifo_active` in, 1: a complete line is waiting in the FIFO (level).
- `i_fifo_line` in, 9: line index of the waiting line.
- `i_fifo_data` in, 12: show-ahead FIFO head word {R,G,B}.
- `i_x_size` in, 12: line length minus one, in words.
- `i_frame_base` in, ADDR_W: base address of frame buffer 0.
- `o_fifo_next` out, 1: FIFO pop strobe.
- `o_fifo_reset` out, 1: one-cycle pulse that clears the capture block's line flag.
- `o_wr_req` out, 1: burst request.
- `i_wr_gnt` in, 1: burst granted.
- `o_wr_addr` out, ADDR_W: burst start address.
- `o_wr_len` out, 7: beats in this burst.
- `o_wr_valid` out, 1: beat valid.
- `i_wr_ready` in, 1: beat accepted.
- `o_wr_data` out, 16: {4'b0, i_fifo_data}.
- `o_wr_last` out, 1: final beat of the burst.
- `o_busy` out, 1: state is not IDLE.
- `o_frame_buf` out, 1: buffer currently being written.
- `o_ovf_cnt` out, 8: saturating count of overrun lines.

## Operation
- States:
  - IDLE: enter LATCH when `i_fifo_active`=1.
  - LATCH: latch `line` and `words` = min(`i_x_size`+1, 512), then go to REQ.
  - REQ: hold `o_wr_req`, `o_wr_addr`, and `o_wr_len` = min(remaining, `BURST_LEN`) stable until `i_wr_gnt`, then go to XFER.
  - XFER: send `o_wr_valid`=1 beats. A beat is accepted when `o_wr_valid` & `i_wr_ready`. On the last accepted beat, go to REQ if remaining>0, otherwise go to DONE.
  - DONE: pulse `o_fifo_reset`, then go to GUARD.
  - GUARD: wait one cycle, then go to IDLE. This lets the level flag fall before IDLE samples it.
- Address = `i_frame_base` + (buf << (STRIDE_LOG2+9)) + (line << STRIDE_LOG2) + beat_offset. Compute modulo 2^ADDR_W; wrap is silent.
- `o_fifo_next` = `o_wr_valid` & `i_wr_ready`. This is combinational, exactly one pop per accepted beat.
- Overrun: in DONE, if `i_fifo_line` != latched line, increment `o_ovf_cnt` (saturates at 255).
- `i_x_size` ≥ 511 clamps to 512 words. `i_x_size`=0 gives one 1-beat burst.
- Mid-transfer changes of `i_x_size` or `i_frame_base` are ignored, because both are latched in LATCH.

## Timing
- Reset values: all outputs 0, state IDLE, buf 0, `o_ovf_cnt` 0.
- `i_fifo_active` rising to `o_wr_req`: 2 cycles (IDLE→LATCH→REQ).
- Grant to first beat: `o_wr_valid` rises the cycle after `i_wr_gnt`.
- `i_wr_ready` may toggle per cycle. Data, address, and `o_wr_last` are held while ready=0.
- Successive bursts: 1 idle cycle (REQ) between bursts at minimum.
- Reset asserted mid-line: immediate return to IDLE with outputs cleared. FIFO contents are not flushed; the partial line is lost.
- `i_fifo_active` while busy: not sampled until IDLE.

## Configuration
- `VCAP_DBUF_EN` defined:
  - In LATCH, when latched line = 0, toggle buf before computing the address (double-buffered frames).
  - `o_frame_buf` drives the buffer being written.
- Undefined:
  - buf is constant 0.
  - `o_frame_buf` is tied 0.

## Structure
- Shared package `vcap_pkg`:
  - state enum
  - `VCAP_FIFO_DEPTH`=512
  - `VCAP_PXL_W`=12
  - `VCAP_LINE_W`=9
- One sub-module, `vcap_burst_split`. It holds the remaining-words and offset counters and produces `o_wr_len`, `o_wr_last`, and the done flag.

## Test plan
- `i_x_size`=15, `BURST_LEN`=8, ready always high: expect 2 bursts of len 8, addresses base+L*512 and base+L*512+8, 16 pops, one `o_fifo_reset` pulse.
- `i_x_size`=9: expect bursts of len 8 then 2; `o_wr_last` on beats 8 and 10; 10 pops.
- Ready toggling 1,0,1,0 during XFER: expect data held on ready=0 cycles, pops equal accepted beats, order preserved.
- `i_fifo_line` changes from 5 to 6 before DONE: expect `o_ovf_cnt` to go 0→1. Force 300 overruns: expect `o_ovf_cnt` saturated at 255.
- Reset pulsed mid-burst: expect all outputs 0 the same cycle and IDLE after release. A following line transfers normally.
- `VCAP_DBUF_EN` defined, lines 0..2 then 0 again: expect `o_frame_buf` 1 then 0. Line 0 address offset is 2^(STRIDE_LOG2+9) when buf=1.
